mult_share_ctrl: RTL and testbench
==================================

Name: mult_share_ctrl

Overview:
- Shares one sequential shift-add multiplier between two requesters.
- Round-robin arbitration; the winning operand pair is latched and multiplied one partial product per clock.
- Result is returned with a one-cycle done pulse tagged with the requester id.
- Sits between client blocks and the multiplier datapath; replaces per-client combinational multipliers.

Parameters:
- WIDTH, 8, operand width in bits; result width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 request; held high with operands stable until ack0
- a0, b0  input  WIDTH  requester 0 multiplicand / multiplier
- req1  input  1  requester 1 request; same rules as req0
- a1, b1  input  WIDTH  requester 1 operands
- ack0, ack1  output  1  one-cycle pulse: request accepted, operands captured
- busy  output  1  high while a multiplication is in progress (RUN or DONE)
- done  output  1  one-cycle pulse: out valid
- done_id  output  1  requester that owns out (0 or 1)
- out  output  2*WIDTH  product; holds its value until the next done

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock is clk, reset is reset.
- Reset values:
  - state=IDLE; ack0=ack1=busy=done=0; done_id=0; out=0.
  - last_winner=1, so requester 0 wins the first tie.
- States:
  - IDLE: if no req, stay.
    - Else choose the winner: a lone requester wins; if both request, the one != last_winner wins.
    - At the edge: latch a/b of the winner, acc=0, cnt=0, ack_winner=1, last_winner=winner, goto RUN.
  - RUN: each edge, if b_reg[cnt], acc += a_reg << cnt, with a_reg zero-extended to 2*WIDTH; then cnt++.
    - On the edge where cnt==WIDTH-1: out <= final acc, done=1, done_id=owner, goto DONE.
  - DONE: one cycle; done deasserts at the next edge; goto IDLE.
- ack is high for exactly the first RUN cycle; never both acks in one cycle.
- Latency: done is asserted WIDTH cycles after the ack cycle. Accept-to-accept minimum is WIDTH+2 cycles (10 for WIDTH=8).
- Requests are not sampled in RUN or DONE. A request pending during a multiply is served in the first IDLE cycle.
- busy = (state != IDLE).
- Arithmetic: unsigned; acc is 2*WIDTH bits and never overflows (max 255*255 = 0xFE01).
- Every operation takes the full WIDTH RUN cycles, including zero operands (no early exit).
- Operands are latched at accept, so later changes or a drop of req/a/b have no effect on the running product.
- A requester that keeps req high after ack is treated as a new request at the next IDLE.
- Reset mid-operation aborts: no done, out cleared to 0, last_winner back to 1.
- Simultaneous reset and req: reset wins; no ack.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default WIDTH
  - counter width, clog2(WIDTH)
- One sub-module is natural: shift_add_mult_seq.
  - Contains the operand registers, acc and cnt.
  - Controlled by start/step/last signals from the FSM in mult_share_ctrl.
- Arbiter and FSM stay in the top module.

Test Plan:
- Reset, then req0 with a0=8'd13, b0=8'd11 -> ack0 in the next cycle; done 8 cycles later; out=16'd143; done_id=0.
- req0 and req1 raised in the same cycle, both held -> ack0 first (out = a0*b0), ack1 at the first IDLE after that done; both served.
- Repeat the simultaneous request -> round-robin alternates; no starvation.
- Boundary operands:
  - a=8'hFF, b=8'hFF -> out=16'hFE01
  - a=0, b=8'hAA -> out=0 after the full 8 cycles
  - a=8'h80, b=8'h01 -> out=16'h0080
- Operand change: req1 with a1=7, b1=9; after ack1, change to a1=200, b1=200 and drop req1 -> out=16'd63, done_id=1.
- Reset pulse in the 4th RUN cycle -> no done; out=0; busy=0 next cycle. A following tie is granted to requester 0.

Source files
------------

// File: rtl/mult_share_ctrl_pkg.sv
// Shared definitions for the two-client multiplier sharing controller:
// FSM state encoding, default operand width and the counter width helper.
package mult_share_ctrl_pkg;

  // Operand width used when the instantiating block does not override it.
  localparam int DEF_WIDTH = 8;

  // Controller states. The fourth encoding is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the partial-product counter, clog2(width). A 1-bit operand
  // still needs a 1-bit counter so the vector is never zero-width.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-add multiplier datapath: holds the latched operands,
// the accumulator and the bit counter. One partial product per step.
// The controlling FSM decides when to load (start) and when to advance
// (step); this block only reports the post-step sum and the last bit.
module shift_add_mult_seq
  import mult_share_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [2*WIDTH-1:0]   prod_next,
  output logic                 last
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] partial;

  // Partial product for the current bit and the accumulator value after it.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned; a missing default would infer a latch.
  always_comb begin
    partial = '0;
    if (b_q[cnt_q]) begin
      partial = {{WIDTH{1'b0}}, a_q} << cnt_q;
    end
    prod_next = acc_q + partial;
    last      = (cnt_q == CW'(WIDTH - 1));
  end

  // Load operands on start, otherwise accumulate one bit per step.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start) begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = '0;
      cnt_d = '0;
    end else if (step) begin
      acc_d = prod_next;
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Datapath registers with synchronous clear.
  // NOTE: reset is sampled only on the clock edge (synchronous), so it is
  // tested inside the edge-triggered block rather than in its sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Two-client front end for one sequential shift-add multiplier.
// Round-robin arbiter picks a requester in IDLE, the operand pair is latched
// into the datapath, WIDTH RUN cycles produce the product, and a one-cycle
// done pulse tagged with the owner's id returns the result.
module mult_share_ctrl
  import mult_share_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic [2*WIDTH-1:0]   out
);

  state_e             state_q, state_d;
  logic               last_winner_q, last_winner_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic [2*WIDTH-1:0] out_q, out_d;

  logic               any_req;
  logic               winner;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic               start;
  logic               step;
  logic [2*WIDTH-1:0] prod_next;
  logic               last;

  // Round-robin arbitration: a lone requester wins, a tie goes to the
  // requester that did not win last time.
  always_comb begin
    any_req = req0 | req1;
    winner  = (req0 && req1) ? ~last_winner_q : req1;
    a_sel   = winner ? a1 : a0;
    b_sel   = winner ? b1 : b0;
  end

  // Next-state and registered-output logic of the controller.
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    done_d        = 1'b0;
    done_id_d     = done_id_q;
    out_d         = out_q;
    start         = 1'b0;
    step          = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          start         = 1'b1;
          ack0_d        = ~winner;
          ack1_d        = winner;
          last_winner_d = winner;
          state_d       = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          out_d     = prod_next;
          done_d    = 1'b1;
          done_id_d = last_winner_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and registered outputs; reset aborts any multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_winner_q <= 1'b1;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      done_q        <= 1'b0;
      done_id_q     <= 1'b0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      done_q        <= done_d;
      done_id_q     <= done_id_d;
      out_q         <= out_d;
    end
  end

  shift_add_mult_seq #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step      (step),
    .a_in      (a_sel),
    .b_in      (b_sel),
    .prod_next (prod_next),
    .last      (last)
  );

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign out     = out_q;

  // Protocol invariants of the registered handshake outputs.
  a_ack_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(ack0 && ack1));
  a_ack_busy: assert property (@(posedge clk) disable iff (reset)
    (ack0 || ack1) |-> busy);
  a_done_pulse: assert property (@(posedge clk) disable iff (reset)
    done |=> !done);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: stimulus pushes the hand-computed
// product when an ack is seen, a monitor pops and compares on every done.
module tb_mult_share_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic        id;
    logic [15:0] prod;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        ack0, ack1, busy, done, done_id;
  logic [15:0] out;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  mult_share_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .ack0    (ack0),
    .ack1    (ack1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .out     (out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expected result.
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_out", 32'(out), 32'(e.prod));
          check("done_id", 32'(done_id), 32'(e.id));
        end
      end
    end
  end

  task automatic check_reset_values();
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_out", 32'(out), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
  endtask

  // Wait (bounded) until the scoreboard is drained.
  task automatic drain(input string name);
    int w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Single request from one client with the DUT idle. After the ack the
  // operands are overwritten with late values that must not affect the result.
  task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp_prod,
                       input logic [7:0] a_late, input logic [7:0] b_late);
    int  k = 0;
    int  ack_cyc;
    bit  got = 1'b0;
    @(negedge clk);
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; end
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (id ? ack1 : ack0) got = 1'b1;
    end
    check("ack_seen", 32'(got), 32'd1);
    check("ack_latency", 32'(k), 32'd1);
    if (got) begin
      sb.push_back('{id, exp_prod});
      ack_cyc = cyc;
      check("busy_in_run", 32'(busy), 32'd1);
    end
    if (id) begin req1 = 1'b0; a1 = a_late; b1 = b_late; end
    else    begin req0 = 1'b0; a0 = a_late; b0 = b_late; end
    if (got) begin
      got = 1'b0;
      k   = 0;
      while (!got && k < 20) begin
        @(negedge clk);
        k++;
        if (done) got = 1'b1;
      end
      check("done_seen", 32'(got), 32'd1);
      check("done_latency", 32'(cyc - ack_cyc), 32'(WIDTH));
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'd0);
      check("out_hold", 32'(out), 32'(exp_prod));
    end
  endtask

  // Both clients hold requests for n grants; grants must alternate starting
  // with 'first' and be spaced by the accept-to-accept minimum.
  task automatic tie(input int n, input bit first,
                     input logic [7:0] x0, input logic [7:0] y0, input logic [15:0] p0,
                     input logic [7:0] x1, input logic [7:0] y1, input logic [15:0] p1);
    int prev = 0;
    bit id;
    @(negedge clk);
    req0 = 1'b1; a0 = x0; b0 = y0;
    req1 = 1'b1; a1 = x1; b1 = y1;
    for (int g = 0; g < n; g++) begin
      int w = 0;
      bit got = 1'b0;
      while (!got && w < 30) begin
        @(negedge clk);
        w++;
        if (ack0 || ack1) got = 1'b1;
      end
      check("tie_ack_seen", 32'(got), 32'd1);
      if (!got) break;
      id = ack1;
      check("tie_grant", 32'(id), 32'(first ^ g[0]));
      if (g > 0) check("tie_gap", 32'(cyc - prev), 32'(WIDTH + 2));
      prev = cyc;
      sb.push_back(id ? '{1'b1, p1} : '{1'b0, p0});
      if (g == n - 1) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    drain("tie_drain");
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check_reset_values();
    mon_en = 1'b1;
    reset  = 1'b0;

    // Basic product from requester 0.
    issue(1'b0, 8'd13, 8'd11, 16'd143, 8'd0, 8'd0);

    // Fresh tie: requester 0 first, then 1, both served.
    do_reset();
    tie(2, 1'b0, 8'd5, 8'd6, 16'd30, 8'd12, 8'd10, 16'd120);
    // Repeated ties keep alternating.
    tie(4, 1'b0, 8'd21, 8'd3, 16'd63, 8'd17, 8'd15, 16'd255);

    // Boundary operands.
    issue(1'b0, 8'hFF, 8'hFF, 16'hFE01, 8'h00, 8'h00);
    issue(1'b1, 8'h00, 8'hAA, 16'h0000, 8'hFF, 8'hFF);
    issue(1'b0, 8'h80, 8'h01, 16'h0080, 8'h7F, 8'hFE);

    // Operands change and req drops after ack.
    issue(1'b1, 8'd7, 8'd9, 16'd63, 8'd200, 8'd200);

    // Reset in the 4th RUN cycle aborts; reset beats a simultaneous request.
    begin
      int  k = 0;
      bit  got = 1'b0;
      @(negedge clk);
      req0 = 1'b1; a0 = 8'd3; b0 = 8'd5;
      while (!got && k < 20) begin
        @(negedge clk);
        k++;
        if (ack0) got = 1'b1;
      end
      check("abort_ack_seen", 32'(got), 32'd1);
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
      req1 = 1'b1; a1 = 8'd4; b1 = 8'd4;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_out", 32'(out), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_no_ack0", 32'(ack0), 32'd0);
      check("abort_no_ack1", 32'(ack1), 32'd0);
      reset = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      // Wait past the cycle where the aborted product would have completed.
      repeat (8) @(negedge clk);
    end
    // Tie after reset goes to requester 0 again.
    tie(1, 1'b0, 8'd9, 8'd9, 16'd81, 8'd4, 8'd4, 16'd16);

    repeat (2) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
